// File: rtl/kp_output_stage.sv
// Output conditioning after the KP voice core: optional DC block, volume, mute fade, saturation.
// Define KP_OUT_DCBLOCK_EN to build the DC-blocking high-pass into stage 1.
module kp_output_stage #(
  parameter int unsigned DW       = 24,
  parameter int unsigned DC_SHIFT = 8,
  parameter int unsigned FADE_W   = 8
) (
  input  logic          a_clk,
  input  logic          reset_n,
  input  logic [DW-1:0] in_sample,
  input  logic          in_valid,
  input  logic          mute,
  input  logic [7:0]    volume,
  input  logic          clip_clr,
  output logic [DW-1:0] out_sample,
  output logic          out_valid,
  output logic          clip,
  output logic [1:0]    fade_state
);

  localparam int unsigned PW = DW + 9;
  localparam int unsigned FW = PW + FADE_W + 2;

  localparam logic [1:0] StMuted   = 2'b00;
  localparam logic [1:0] StFadeIn  = 2'b01;
  localparam logic [1:0] StRun     = 2'b10;
  localparam logic [1:0] StFadeOut = 2'b11;

  localparam logic [FADE_W:0] GainMax = {1'b1, {FADE_W{1'b0}}};
  localparam logic [FADE_W:0] GainOne = {{FADE_W{1'b0}}, 1'b1};

  localparam logic signed [DW-1:0] SampMax = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SampMin = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] y_q, y_d;
  logic signed [PW-1:0] p_q, p_d;
  logic signed [DW-1:0] out_q, out_d;
  logic                 v1_q, v2_q, out_valid_q;
  logic                 clip_q, clamp_act;
  logic [1:0]           state_q, state_d;
  logic [FADE_W:0]      gain_q, gain_d;

  // Stage 1: DC blocker or plain register
`ifdef KP_OUT_DCBLOCK_EN
  localparam int unsigned IW = DW + 4;
  localparam logic signed [IW-1:0] DcMax = {{(IW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [IW-1:0] DcMin = {{(IW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0] x_prev_q;
  logic signed [IW-1:0] x_ext, xp_ext, yp_ext, dc_sum;

  always_comb begin
    x_ext  = $signed({{(IW-DW){in_sample[DW-1]}}, in_sample});
    xp_ext = $signed({{(IW-DW){x_prev_q[DW-1]}}, x_prev_q});
    yp_ext = $signed({{(IW-DW){y_q[DW-1]}}, y_q});
    dc_sum = x_ext - xp_ext + yp_ext - (yp_ext >>> DC_SHIFT);
    if (dc_sum > DcMax) begin
      y_d = SampMax;
    end else if (dc_sum < DcMin) begin
      y_d = SampMin;
    end else begin
      y_d = dc_sum[DW-1:0];
    end
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      x_prev_q <= '0;
    end else if (in_valid) begin
      x_prev_q <= in_sample;
    end
  end
`else
  assign y_d = in_sample;
`endif

  // Stage 2: volume, 128 = unity
  logic signed [PW-1:0] y_ext, vol_ext, prod2;
  always_comb begin
    y_ext   = $signed({{(PW-DW){y_q[DW-1]}}, y_q});
    vol_ext = $signed({{(PW-8){1'b0}}, volume});
    prod2   = y_ext * vol_ext;
    p_d     = prod2 >>> 7;
  end

  // Stage 3: fade gain and final saturation
  localparam logic signed [FW-1:0] OutMax = {{(FW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [FW-1:0] OutMin = {{(FW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [FW-1:0] p_ext, g_ext, prod3, f_val;
  always_comb begin
    p_ext     = $signed({{(FW-PW){p_q[PW-1]}}, p_q});
    g_ext     = $signed({{(FW-FADE_W-1){1'b0}}, gain_q});
    prod3     = p_ext * g_ext;
    f_val     = prod3 >>> FADE_W;
    clamp_act = 1'b0;
    if (f_val > OutMax) begin
      out_d     = SampMax;
      clamp_act = 1'b1;
    end else if (f_val < OutMin) begin
      out_d     = SampMin;
      clamp_act = 1'b1;
    end else begin
      out_d = f_val[DW-1:0];
    end
  end

  // Fade FSM; direction reversals keep the current gain so the ramp is continuous
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      StMuted: begin
        gain_d = '0;
        if (!mute) state_d = StFadeIn;
      end
      StFadeIn: begin
        if (mute) begin
          state_d = StFadeOut;
        end else if (gain_q >= GainMax - GainOne) begin
          gain_d  = GainMax;
          state_d = StRun;
        end else begin
          gain_d = gain_q + GainOne;
        end
      end
      StRun: begin
        gain_d = GainMax;
        if (mute) state_d = StFadeOut;
      end
      StFadeOut: begin
        if (!mute) begin
          state_d = StFadeIn;
        end else if (gain_q <= GainOne) begin
          gain_d  = '0;
          state_d = StMuted;
        end else begin
          gain_d = gain_q - GainOne;
        end
      end
      default: begin
        state_d = StMuted;
        gain_d  = '0;
      end
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      y_q     <= '0;
      p_q     <= '0;
      out_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      state_q <= StMuted;
      gain_q  <= '0;
    end else if (in_valid) begin
      y_q     <= y_d;
      p_q     <= p_d;
      out_q   <= out_d;
      v1_q    <= 1'b1;
      v2_q    <= v1_q;
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      out_valid_q <= in_valid & v2_q;
      if (in_valid && clamp_act) begin
        clip_q <= 1'b1;
      end else if (clip_clr) begin
        clip_q <= 1'b0;
      end
    end
  end

  assign out_sample = out_q;
  assign out_valid  = out_valid_q;
  assign clip       = clip_q;
  assign fade_state = state_q;

endmodule
